// File: rtl/ev20_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ev20_pkg
// Description : Shared definitions for the EV-20 instruction sequencer:
//               opcodes, FSM state encoding and instruction field positions.
// Revision    : 1.0 - initial release
// ============================================================================
package ev20_pkg;

  // Opcodes held in instruction bits [31:28]; 8..15 are undefined
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ALU  = 4'd1;
  localparam logic [3:0] OP_LDI  = 4'd2;
  localparam logic [3:0] OP_LD   = 4'd3;
  localparam logic [3:0] OP_ST   = 4'd4;
  localparam logic [3:0] OP_JMP  = 4'd5;
  localparam logic [3:0] OP_JC   = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd7;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_LATCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  // Instruction field positions
  localparam int c_opc_hi  = 31;
  localparam int c_opc_lo  = 28;
  localparam int c_aluc_hi = 27;
  localparam int c_aluc_lo = 24;
  localparam int c_rc_hi   = 23;
  localparam int c_rc_lo   = 18;
  localparam int c_ra_hi   = 17;
  localparam int c_ra_lo   = 12;
  localparam int c_uc_bit  = 8;
  localparam int c_shf_hi  = 7;
  localparam int c_shf_lo  = 6;
  localparam int c_rb_hi   = 5;
  localparam int c_rb_lo   = 0;
  localparam int c_k_hi    = 15;
  localparam int c_k_lo    = 0;
  localparam int c_addr_hi = 9;
  localparam int c_addr_lo = 0;

  // Undefined opcodes are exactly those with the top bit set
  function automatic logic op_is_illegal(input logic [3:0] opc);
    return opc[3];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ev20_decode.sv
`default_nettype none
// ============================================================================
// Module      : ev20_decode
// Description : Combinational decode of instruction register and sequencer
//               state into the datapath control word.
// Revision    : 1.0 - initial release
// ============================================================================
module ev20_decode
  import ev20_pkg::*;
#(
  parameter int PA_W = 10,
  parameter int DA_W = 10,
  parameter int RS_W = 6
) (
  input  logic [31:0]     i_ir,
  input  state_t          i_state,
  input  logic [PA_W-1:0] i_pc,
  input  logic            i_cf,
  output logic [PA_W-1:0] o_paddr,
  output logic            o_prd,
  output logic [RS_W-1:0] o_sel_a,
  output logic [RS_W-1:0] o_sel_b,
  output logic [RS_W-1:0] o_sel_c,
  output logic [3:0]      o_aluc,
  output logic [1:0]      o_shf,
  output logic            o_kmx_sel,
  output logic [15:0]     o_kmx,
  output logic [DA_W-1:0] o_daddr,
  output logic            o_rd,
  output logic            o_wr,
  output logic            o_cy_in,
  output logic            o_halted
);

  logic [3:0]      w_opc;
  logic [RS_W-1:0] w_ra;
  logic [RS_W-1:0] w_rb;
  logic [RS_W-1:0] w_rc;
  logic [DA_W-1:0] w_addr;

  assign w_opc  = i_ir[c_opc_hi:c_opc_lo];
  assign w_ra   = RS_W'(i_ir[c_ra_hi:c_ra_lo]);
  assign w_rb   = RS_W'(i_ir[c_rb_hi:c_rb_lo]);
  assign w_rc   = RS_W'(i_ir[c_rc_hi:c_rc_lo]);
  assign w_addr = DA_W'(i_ir[c_addr_hi:c_addr_lo]);

  // Everything defaults to zero so that a zero register select means no write
  always_comb begin
    o_paddr   = '0;
    o_prd     = 1'b0;
    o_sel_a   = '0;
    o_sel_b   = '0;
    o_sel_c   = '0;
    o_aluc    = '0;
    o_shf     = '0;
    o_kmx_sel = 1'b0;
    o_kmx     = '0;
    o_daddr   = '0;
    o_rd      = 1'b0;
    o_wr      = 1'b0;
    o_cy_in   = 1'b0;
    o_halted  = 1'b0;
    case (i_state)
      ST_FETCH: begin
        o_paddr = i_pc;
        o_prd   = 1'b1;
      end
      ST_EXEC: begin
        case (w_opc)
          OP_ALU: begin
            o_sel_a = w_ra;
            o_sel_b = w_rb;
            o_sel_c = w_rc;
            o_aluc  = i_ir[c_aluc_hi:c_aluc_lo];
            o_shf   = i_ir[c_shf_hi:c_shf_lo];
            o_cy_in = i_ir[c_uc_bit] & i_cf;
          end
          OP_LDI: begin
            o_kmx_sel = 1'b1;
            o_kmx     = i_ir[c_k_hi:c_k_lo];
            o_sel_c   = w_rc;
          end
          OP_LD: begin
            o_daddr = w_addr;
            o_rd    = 1'b1;
          end
          OP_ST: begin
            o_daddr = w_addr;
            o_sel_a = w_ra;
            o_wr    = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        // Second load cycle: hold the read and write the data back
        o_daddr = w_addr;
        o_rd    = 1'b1;
        o_sel_c = w_rc;
      end
      ST_HALT: o_halted = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ev20_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : ev20_ctrl_seq
// Description : EV-20 instruction fetch/decode/sequence unit. Owns the FSM,
//               program counter, instruction register, carry flag and the
//               sticky illegal-opcode flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ev20_ctrl_seq
  import ev20_pkg::*;
#(
  parameter int PA_W = 10,
  parameter int DA_W = 10,
  parameter int RS_W = 6
) (
  input  logic            CLK,
  input  logic            RST_N,
  output logic [PA_W-1:0] PAddr,
  output logic            PRd,
  input  logic [31:0]     PData,
  output logic [RS_W-1:0] SEL_A_RB,
  output logic [RS_W-1:0] SEL_B_RB,
  output logic [RS_W-1:0] C_SEL_RB,
  output logic [3:0]      ALUC_IN,
  output logic [1:0]      Shifter_Sel,
  output logic            Y_X_Kmx_Sel,
  output logic [15:0]     Y_KMx_IN,
  output logic [DA_W-1:0] DAddr,
  output logic            Rd,
  output logic            Wr,
  output logic            CY_IN,
  input  logic            CY_OUT,
  output logic            HALTED,
  output logic            ILLEGAL
);

  state_t          r_state;
  logic [PA_W-1:0] r_pc;
  logic [31:0]     r_ir;
  logic            r_cf;
  logic            r_illegal;

  logic [3:0]      w_opc;
  logic [PA_W-1:0] w_jmp_tgt;
  logic            w_prd;

  assign w_opc     = r_ir[c_opc_hi:c_opc_lo];
  assign w_jmp_tgt = PA_W'(r_ir[c_addr_hi:c_addr_lo]);

  // Sequencer: fetch, latch IR and bump PC, execute, optional load cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= ST_FETCH;
      r_pc      <= '0;
      r_ir      <= '0;
      r_cf      <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: r_state <= ST_LATCH;
        ST_LATCH: begin
          r_ir    <= PData;
          r_pc    <= r_pc + PA_W'(1);
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_state <= ST_FETCH;
          if (op_is_illegal(w_opc)) begin
            r_illegal <= 1'b1;
          end else begin
            case (w_opc)
              OP_ALU:  r_cf    <= CY_OUT;
              OP_LD:   r_state <= ST_MEM;
              // PC already points past this instruction; a taken jump overrides it
              OP_JMP:  r_pc    <= w_jmp_tgt;
              OP_JC:   if (r_cf) r_pc <= w_jmp_tgt;
              OP_HALT: r_state <= ST_HALT;
              default: ;
            endcase
          end
        end
        ST_MEM:  r_state <= ST_FETCH;
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  ev20_decode #(
    .PA_W (PA_W),
    .DA_W (DA_W),
    .RS_W (RS_W)
  ) u_decode (
    .i_ir      (r_ir),
    .i_state   (r_state),
    .i_pc      (r_pc),
    .i_cf      (r_cf),
    .o_paddr   (PAddr),
    .o_prd     (w_prd),
    .o_sel_a   (SEL_A_RB),
    .o_sel_b   (SEL_B_RB),
    .o_sel_c   (C_SEL_RB),
    .o_aluc    (ALUC_IN),
    .o_shf     (Shifter_Sel),
    .o_kmx_sel (Y_X_Kmx_Sel),
    .o_kmx     (Y_KMx_IN),
    .o_daddr   (DAddr),
    .o_rd      (Rd),
    .o_wr      (Wr),
    .o_cy_in   (CY_IN),
    .o_halted  (HALTED)
  );

  // The reset state is FETCH, so the ROM strobe is masked while reset is held
  assign PRd     = w_prd & RST_N;
  assign ILLEGAL = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_ev20_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ev20_ctrl_seq
// Description : Self-checking bench for ev20_ctrl_seq: directed vector table,
//               hand-written halt/reset sequences and a random program run
//               against an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ev20_ctrl_seq;

  typedef struct packed {
    logic [9:0]  paddr;
    logic        prd;
    logic [5:0]  sela;
    logic [5:0]  selb;
    logic [5:0]  csel;
    logic [3:0]  aluc;
    logic [1:0]  shf;
    logic        ksel;
    logic [15:0] k;
    logic [9:0]  daddr;
    logic        rd;
    logic        wr;
    logic        cyin;
    logic        halted;
    logic        ill;
  } ctl_t;

  typedef struct {
    logic [9:0]  at;
    logic [31:0] ins;
    logic        cy;
    logic        ld;
    ctl_t        ex;
    ctl_t        mem;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [9:0]  PAddr;
  logic        PRd;
  logic [31:0] pdata = '0;
  logic [5:0]  SEL_A_RB, SEL_B_RB, C_SEL_RB;
  logic [3:0]  ALUC_IN;
  logic [1:0]  Shifter_Sel;
  logic        Y_X_Kmx_Sel;
  logic [15:0] Y_KMx_IN;
  logic [9:0]  DAddr;
  logic        Rd, Wr, CY_IN;
  logic        CY_OUT = 1'b0;
  logic        HALTED, ILLEGAL;

  logic [31:0] rom [1024];
  vec_t        tbl [11];
  int          nv = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model architectural state
  logic [9:0]  m_pc;
  logic        m_cf;
  logic        m_ill;

  ev20_ctrl_seq dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .PAddr       (PAddr),
    .PRd         (PRd),
    .PData       (pdata),
    .SEL_A_RB    (SEL_A_RB),
    .SEL_B_RB    (SEL_B_RB),
    .C_SEL_RB    (C_SEL_RB),
    .ALUC_IN     (ALUC_IN),
    .Shifter_Sel (Shifter_Sel),
    .Y_X_Kmx_Sel (Y_X_Kmx_Sel),
    .Y_KMx_IN    (Y_KMx_IN),
    .DAddr       (DAddr),
    .Rd          (Rd),
    .Wr          (Wr),
    .CY_IN       (CY_IN),
    .CY_OUT      (CY_OUT),
    .HALTED      (HALTED),
    .ILLEGAL     (ILLEGAL)
  );

  always #5 CLK = ~CLK;

  // Synchronous program ROM: data appears the cycle after the read strobe
  always @(posedge CLK) if (PRd) pdata <= rom[PAddr];

  function automatic logic [31:0] f_alu(int a, int b, int c, int aluc, int shf, int uc);
    return {4'h1, 4'(aluc), 6'(c), 6'(a), 3'b000, 1'(uc), 2'(shf), 6'(b)};
  endfunction

  function automatic logic [31:0] f_ldi(int c, int k);
    return {4'h2, 4'h0, 6'(c), 2'b00, 16'(k)};
  endfunction

  function automatic logic [31:0] f_mem(int op, int c, int a, int addr);
    return {4'(op), 4'h0, 6'(c), 6'(a), 2'b00, 10'(addr)};
  endfunction

  function automatic ctl_t idle(input logic ill);
    ctl_t e;
    e = '0;
    e.ill = ill;
    return e;
  endfunction

  function automatic ctl_t fetch_exp(input logic [9:0] pc, input logic ill);
    ctl_t e;
    e = idle(ill);
    e.paddr = pc;
    e.prd = 1'b1;
    return e;
  endfunction

  // PAddr is only meaningful while the ROM strobe is up
  function automatic ctl_t sample();
    ctl_t s;
    s.paddr  = PRd ? PAddr : 10'd0;
    s.prd    = PRd;
    s.sela   = SEL_A_RB;
    s.selb   = SEL_B_RB;
    s.csel   = C_SEL_RB;
    s.aluc   = ALUC_IN;
    s.shf    = Shifter_Sel;
    s.ksel   = Y_X_Kmx_Sel;
    s.k      = Y_KMx_IN;
    s.daddr  = DAddr;
    s.rd     = Rd;
    s.wr     = Wr;
    s.cyin   = CY_IN;
    s.halted = HALTED;
    s.ill    = ILLEGAL;
    return s;
  endfunction

  task automatic check(input string nm, input ctl_t exp);
    ctl_t act;
    act = sample();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Leaves the bench at a negedge with the DUT in its first FETCH cycle
  task automatic do_reset();
    RST_N = 1'b0;
    @(negedge CLK);
    check("reset_state", idle(1'b0));
    @(posedge CLK);
    #2 RST_N = 1'b1;
    @(negedge CLK);
    m_pc = '0;
    m_cf = 1'b0;
    m_ill = 1'b0;
  endtask

  task automatic add(input logic [9:0] at, input logic [31:0] ins, input logic cy,
                     input logic ld, input ctl_t ex, input ctl_t mem);
    tbl[nv].at  = at;
    tbl[nv].ins = ins;
    tbl[nv].cy  = cy;
    tbl[nv].ld  = ld;
    tbl[nv].ex  = ex;
    tbl[nv].mem = mem;
    nv++;
  endtask

  // Instruction-level reference: predicts every cycle of the instruction at m_pc
  task automatic run_model(input logic cy);
    logic [31:0] ins;
    logic [3:0]  op;
    ctl_t        e;
    ins = rom[m_pc];
    op = ins[31:28];
    CY_OUT = cy;
    check("rnd_fetch", fetch_exp(m_pc, m_ill));
    cyc();
    check("rnd_latch", idle(m_ill));
    cyc();
    m_pc = m_pc + 10'd1;
    e = idle(m_ill);
    case (op)
      4'd1: begin
        e.sela = ins[17:12]; e.selb = ins[5:0]; e.csel = ins[23:18];
        e.aluc = ins[27:24]; e.shf = ins[7:6]; e.cyin = ins[8] && m_cf;
      end
      4'd2: begin e.ksel = 1'b1; e.k = ins[15:0]; e.csel = ins[23:18]; end
      4'd3: begin e.daddr = ins[9:0]; e.rd = 1'b1; end
      4'd4: begin e.daddr = ins[9:0]; e.sela = ins[17:12]; e.wr = 1'b1; end
      4'd5: m_pc = ins[9:0];
      4'd6: if (m_cf) m_pc = ins[9:0];
      default: ;
    endcase
    check("rnd_exec", e);
    cyc();
    if (op == 4'd1) m_cf = cy;
    if (op >= 4'd8) m_ill = 1'b1;
    if (op == 4'd3) begin
      e = idle(m_ill);
      e.daddr = ins[9:0]; e.rd = 1'b1; e.csel = ins[23:18];
      check("rnd_mem", e);
      cyc();
    end
    if (op == 4'd7) begin
      e = idle(m_ill);
      e.halted = 1'b1;
      repeat (3) begin
        check("rnd_halt", e);
        cyc();
      end
      do_reset();
    end
  endtask

  initial begin
    ctl_t e, z;
    z = '0;
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0;

    // ---------------- directed vector table ----------------
    e = idle(0); e.csel = 6'd5; e.ksel = 1'b1; e.k = 16'h1234;
    add(10'h000, f_ldi(5, 16'h1234), 1'b1, 1'b0, e, z);
    e = idle(0); e.sela = 6'd1; e.selb = 6'd2; e.csel = 6'd3; e.aluc = 4'd4; e.shf = 2'd2;
    add(10'h001, f_alu(1, 2, 3, 4, 2, 1), 1'b1, 1'b0, e, z);
    e.cyin = 1'b1;
    add(10'h002, f_alu(1, 2, 3, 4, 2, 1), 1'b0, 1'b0, e, z);
    e = idle(0); e.daddr = 10'h3FF; e.rd = 1'b1;
    z = e; z.csel = 6'd7;
    add(10'h003, f_mem(3, 7, 0, 10'h3FF), 1'b1, 1'b1, e, z);
    z = '0;
    e = idle(0); e.daddr = 10'h155; e.sela = 6'd9; e.wr = 1'b1;
    add(10'h004, f_mem(4, 0, 9, 10'h155), 1'b1, 1'b0, e, z);
    add(10'h005, f_mem(6, 0, 0, 10'h020), 1'b0, 1'b0, idle(0), z);
    e = idle(0); e.csel = 6'd1;
    add(10'h006, f_alu(0, 0, 1, 0, 0, 0), 1'b1, 1'b0, e, z);
    add(10'h007, f_mem(6, 0, 0, 10'h020), 1'b0, 1'b0, idle(0), z);
    add(10'h020, f_mem(5, 0, 0, 10'h3FF), 1'b0, 1'b0, idle(0), z);
    add(10'h3FF, 32'hA5F3_C1DE, 1'b1, 1'b0, idle(0), z);
    e = idle(1); e.csel = 6'd5; e.ksel = 1'b1; e.k = 16'h1234;
    add(10'h000, f_ldi(5, 16'h1234), 1'b0, 1'b0, e, z);
    for (int i = 0; i < nv; i++) rom[tbl[i].at] = tbl[i].ins;

    do_reset();
    for (int i = 0; i < nv; i++) begin
      CY_OUT = tbl[i].cy;
      check($sformatf("vec%0d_fetch", i), fetch_exp(tbl[i].at, tbl[i].ex.ill));
      cyc();
      check($sformatf("vec%0d_latch", i), idle(tbl[i].ex.ill));
      cyc();
      check($sformatf("vec%0d_exec", i), tbl[i].ex);
      cyc();
      if (tbl[i].ld) begin
        check($sformatf("vec%0d_mem", i), tbl[i].mem);
        cyc();
      end
    end

    // ---------------- illegal opcode then HALT ----------------
    rom[0] = 32'hA000_0000;
    rom[1] = 32'h7000_0000;
    do_reset();
    check("ill_fetch", fetch_exp(10'h000, 1'b0)); cyc();
    check("ill_latch", idle(1'b0)); cyc();
    check("ill_exec", idle(1'b0)); cyc();
    check("halt_fetch", fetch_exp(10'h001, 1'b1)); cyc();
    check("halt_latch", idle(1'b1)); cyc();
    check("halt_exec", idle(1'b1)); cyc();
    e = idle(1'b1); e.halted = 1'b1;
    repeat (5) begin
      check("halted_hold", e);
      cyc();
    end

    // ---------------- reset asserted in the middle of EXEC ----------------
    rom[1] = f_mem(4, 0, 3, 10'h100);
    do_reset();
    repeat (5) cyc();
    e = idle(1'b1); e.daddr = 10'h100; e.sela = 6'd3; e.wr = 1'b1;
    check("st_exec_pre_reset", e);
    #2 RST_N = 1'b0;
    #1 check("mid_exec_reset", idle(1'b0));
    @(posedge CLK);
    #2 RST_N = 1'b1;
    @(negedge CLK);
    check("restart_fetch", fetch_exp(10'h000, 1'b0));

    // ---------------- random program against the reference model ----------------
    for (int i = 0; i < 1024; i++) rom[i] = $urandom();
    do_reset();
    for (int n = 0; n < 400; n++) run_model(1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
